// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the CPU fetch (I) and load/store (D) ports.
// Serialises accesses as IDLE -> ACCESS -> WAIT -> RESP and returns read data in per-port registers.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int PRIO_MODE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       last_grant_d;
  logic       grant_d;
  logic       grant_rd;
  logic       pick_d;

  // Tie-break: round-robin toggles away from the last winner; priority mode always favours D.
  always_comb begin
    pick_d = 1'b0;
    if (d_req && !i_req) begin
      pick_d = 1'b1;
    end else if (d_req && i_req) begin
      pick_d = (PRIO_MODE != 0) ? 1'b1 : !last_grant_d;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      last_grant_d <= 1'b1;
      grant_d      <= 1'b0;
      grant_rd     <= 1'b0;
      mem_cs       <= 1'b0;
      mem_we       <= 4'h0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      i_rdata      <= 32'h0;
      d_rdata      <= 32'h0;
    end else begin
      mem_cs  <= 1'b0;
      mem_we  <= 4'h0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state        <= ACCESS;
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            grant_rd     <= !pick_d || (d_we == 4'h0);
            mem_cs       <= 1'b1;
            mem_addr     <= pick_d ? d_addr : i_addr;
            mem_we       <= pick_d ? d_we : 4'h0;
            mem_wdata    <= pick_d ? d_wdata : 32'h0;
          end
        end
        ACCESS: begin
          state    <= WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          // Read data is captured on the edge leaving WAIT so it is visible alongside valid.
          if (wait_cnt == 4'd0) begin
            state   <= RESP;
            d_valid <= grant_d;
            i_valid <= !grant_d;
            if (grant_rd) begin
              if (grant_d) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
